mxn_logic_result_stage: RTL and testbench



---
 rtl/mxn_logic_result_stage.sv | 137 +++++++++++++
 tb/tb_mxn_logic_result_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mxn_logic_result_stage.sv
// Registered result stage for the m x n-bit logic gate bank: bitwise gate evaluation,
// 2-entry result FIFO with tag/zero/parity flags. Optional parity storage: MXN_PARITY_EN.
module mxn_logic_result_stage #(
   parameter int WIDTH = 4,
   parameter int SETS  = 2,
   parameter int TAG_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              op,
   input  logic [SETS*WIDTH-1:0]   in1_packed,
   input  logic [SETS*WIDTH-1:0]   in2_packed,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SETS*WIDTH-1:0]   out_packed,
   output logic [2:0]              out_op,
   output logic [TAG_W-1:0]        out_tag,
   output logic [SETS-1:0]         out_zero,
   output logic [SETS-1:0]         out_parity
);

   localparam int DW = SETS * WIDTH;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   // Handshakes: a transfer happens on an edge where valid && ready. in_ready is a
   // function of FIFO occupancy only, so a pop while FULL never admits a push that cycle.
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [TAG_W-1:0] tag_cnt;
   logic             push;
   logic             pop;

   logic [DW-1:0]    result;
   logic [SETS-1:0]  zero_c;

   logic [DW-1:0]    res_mem  [2];
   logic [2:0]       op_mem   [2];
   logic [TAG_W-1:0] tag_mem  [2];
   logic [SETS-1:0]  zero_mem [2];

   function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] code,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      case (code)
         3'd0:    r = ~a;
         3'd1:    r = a & b;
         3'd2:    r = a | b;
         3'd3:    r = ~(a & b);
         3'd4:    r = ~(a | b);
         3'd5:    r = a ^ b;
         3'd6:    r = ~(a ^ b);
         default: r = a;
      endcase
      return r;
   endfunction

   for (genvar g = 0; g < SETS; g++) begin : g_set
      assign result[g*WIDTH +: WIDTH] = gate_eval(op, in1_packed[g*WIDTH +: WIDTH],
                                                  in2_packed[g*WIDTH +: WIDTH]);
      assign zero_c[g] = ~|result[g*WIDTH +: WIDTH];
   end

   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (push) state_nxt = ST_ONE;
         ST_ONE: begin
            if (push && !pop)      state_nxt = ST_FULL;
            else if (pop && !push) state_nxt = ST_EMPTY;
         end
         ST_FULL:  if (pop) state_nxt = ST_ONE;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_EMPTY;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         tag_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (push) begin
            wr_ptr  <= ~wr_ptr;
            tag_cnt <= tag_cnt + 1'b1;
         end
         if (pop) rd_ptr <= ~rd_ptr;
      end
   end

   // Storage needs no reset: every read is masked by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         res_mem[wr_ptr]  <= result;
         op_mem[wr_ptr]   <= op;
         tag_mem[wr_ptr]  <= tag_cnt;
         zero_mem[wr_ptr] <= zero_c;
      end
   end

   assign out_packed = out_valid ? res_mem[rd_ptr]  : '0;
   assign out_op     = out_valid ? op_mem[rd_ptr]   : '0;
   assign out_tag    = out_valid ? tag_mem[rd_ptr]  : '0;
   assign out_zero   = out_valid ? zero_mem[rd_ptr] : '0;

`ifdef MXN_PARITY_EN
   logic [SETS-1:0] parity_c;
   logic [SETS-1:0] par_mem [2];

   for (genvar p = 0; p < SETS; p++) begin : g_par
      assign parity_c[p] = ^result[p*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk) begin
      if (push) par_mem[wr_ptr] <= parity_c;
   end

   assign out_parity = out_valid ? par_mem[rd_ptr] : '0;
`else
   assign out_parity = '0;
`endif

endmodule

// File: tb/tb_mxn_logic_result_stage.sv
// Bench for mxn_logic_result_stage: directed steps plus randomized traffic against a
// queue-based reference model of the result FIFO.
module tb_mxn_logic_result_stage;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] op = '0;
   logic [7:0] in1_packed = '0;
   logic [7:0] in2_packed = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_packed;
   logic [2:0] out_op;
   logic [7:0] out_tag;
   logic [1:0] out_zero;
   logic [1:0] out_parity;

   mxn_logic_result_stage #(.WIDTH(4), .SETS(2), .TAG_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .in1_packed(in1_packed), .in2_packed(in2_packed), .out_valid(out_valid),
      .out_ready(out_ready), .out_packed(out_packed), .out_op(out_op),
      .out_tag(out_tag), .out_zero(out_zero), .out_parity(out_parity)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] res;
      logic [2:0] op;
      logic [7:0] tag;
      logic [1:0] zero;
      logic [1:0] par;
   } ent_t;

   ent_t       exp_q[$];
   logic [7:0] popped_tags[$];
   int         model_tag = 0;
   int         n_push = 0;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t make_entry(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
      ent_t e;
      logic [3:0] s;
      case (o)
         3'd0: e.res = ~a;
         3'd1: e.res = a & b;
         3'd2: e.res = a | b;
         3'd3: e.res = ~(a & b);
         3'd4: e.res = ~(a | b);
         3'd5: e.res = a ^ b;
         3'd6: e.res = ~(a ^ b);
         default: e.res = a;
      endcase
      e.op  = o;
      e.tag = model_tag[7:0];
      for (int i = 0; i < 2; i++) begin
         s = e.res[i*4 +: 4];
         e.zero[i] = (s == 4'h0);
`ifdef MXN_PARITY_EN
         e.par[i] = ^s;
`else
         e.par[i] = 1'b0;
`endif
      end
      return e;
   endfunction

   task automatic check_outputs();
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         chk("out_packed", out_packed, exp_q[0].res);
         chk("out_op", out_op, exp_q[0].op);
         chk("out_tag", out_tag, exp_q[0].tag);
         chk("out_zero", out_zero, exp_q[0].zero);
         chk("out_parity", out_parity, exp_q[0].par);
      end
   endtask

   // One cycle: drive after posedge, check at negedge, advance model, return posedge+1.
   task automatic step(input logic v, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic r);
      bit do_push;
      bit do_pop;
      in_valid = v; op = o; in1_packed = a; in2_packed = b; out_ready = r;
      @(negedge clk);
      check_outputs();
      do_pop  = (exp_q.size() > 0) && r;
      do_push = v && (exp_q.size() < 2);
      if (do_pop) begin
         popped_tags.push_back(out_tag);
         void'(exp_q.pop_front());
      end
      if (do_push) begin
         exp_q.push_back(make_entry(o, a, b));
         model_tag = (model_tag + 1) % 256;
         n_push++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      popped_tags.delete();
      model_tag = 0;
      n_push = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic [7:0] lit_res [8];
   logic [7:0] ra, rb;
   int         cyc;

   initial begin
      lit_res = '{8'h5A, 8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'hA5};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_packed", out_packed, 8'h00);
      chk("reset_out_op", out_op, 3'd0);
      chk("reset_out_tag", out_tag, 8'h00);
      chk("reset_out_zero", out_zero, 2'b00);
      chk("reset_out_parity", out_parity, 2'b00);
      rst = 1'b0;

      // All opcodes back-to-back on A5/3C: one result per cycle, tags 0..7
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 3'(i), 8'hA5, 8'h3C, 1'b1);
         chk("op_table_valid", out_valid, 1'b1);
         chk("op_table_res", out_packed, lit_res[i]);
         chk("op_table_tag", out_tag, 32'(i));
      end
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Zero and parity flags
      step(1'b1, 3'd1, 8'hF0, 8'h0F, 1'b1);
      chk("zero_res", out_packed, 8'h00);
      chk("zero_flags_set", out_zero, 2'b11);
      step(1'b1, 3'd1, 8'hA5, 8'h3C, 1'b1);
      chk("zero_flags_clear", out_zero, 2'b00);
`ifdef MXN_PARITY_EN
      chk("parity_and", out_parity, 2'b11);
`else
      chk("parity_and", out_parity, 2'b00);
`endif
      step(1'b1, 3'd5, 8'hA5, 8'h3C, 1'b1);
      chk("parity_xor", out_parity, 2'b00);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // Backpressure from a fresh reset: third push held, pop-only while FULL
      do_reset();
      for (int i = 0; i < 3; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         step(1'b1, 3'($urandom_range(0, 7)), ra, rb, 1'b0);
         if (i == 1) chk("bp_in_ready_low", in_ready, 1'b0);
      end
      chk("bp_full_still", in_ready, 1'b0);
      step(1'b1, 3'd2, ra, rb, 1'b1);
      chk("bp_pop_only_in_ready", in_ready, 1'b1);
      chk("bp_pop_only_tag", out_tag, 8'd1);
      step(1'b1, 3'd2, ra, rb, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      chk("bp_pop_count", popped_tags.size(), 3);
      if (popped_tags.size() == 3) begin
         chk("bp_tag0", popped_tags[0], 8'd0);
         chk("bp_tag1", popped_tags[1], 8'd1);
         chk("bp_tag2", popped_tags[2], 8'd2);
      end

      // Reset while FULL discards both entries at once
      step(1'b1, 3'd1, 8'h11, 8'h22, 1'b0);
      step(1'b1, 3'd2, 8'h33, 8'h44, 1'b0);
      chk("full_before_rst", in_ready, 1'b0);
      do_reset();

      // Randomized traffic: 257 pushes, tag wraps 255 -> 0
      cyc = 0;
      while (n_push < 257 && cyc < 5000) begin
         step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 3) != 0));
         cyc++;
      end
      chk("push_budget", n_push, 257);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 10) begin
         step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
         cyc++;
      end
      chk("drain_empty", out_valid, 1'b0);
      chk("wrap_pop_count", popped_tags.size(), 257);
      if (popped_tags.size() == 257) begin
         chk("wrap_tag255", popped_tags[255], 8'd255);
         chk("wrap_final_tag", popped_tags[256], 8'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
